// File: rtl/fl_alloc_ctrl_pkg.sv
// Shared constants, FSM encoding and small helpers for the free-list allocation controller.
package fl_alloc_ctrl_pkg;

  localparam int unsigned NUM_PR    = 96;
  localparam int unsigned NUM_ARCH  = 32;
  localparam int unsigned FREE_INIT = NUM_PR - NUM_ARCH;
  localparam int unsigned CNT_W     = 7;

  typedef enum logic {
    StNormal  = 1'b0,
    StRecover = 1'b1
  } fl_state_e;

  // Clamp a 2-bit request/retire count to at most 2 (encoding 3 means 2).
  function automatic logic [1:0] min2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd2 : v;
  endfunction

endpackage

// File: rtl/fl_alloc_ctrl.sv
// Allocation controller: grants up to two destination tags per cycle from the
// free-register pool, stalls dispatch when the pool is short, and sequences
// free-list rollback (two tags per cycle) after a ROB squash.
module fl_alloc_ctrl
  import fl_alloc_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       id_req_num,
  input  logic [1:0]       rob_retire_num,
  input  logic             rob_squash,
  input  logic [CNT_W-1:0] rob_squash_cnt,
  output logic [1:0]       fl_dispatch_num,
  output logic [1:0]       fl_rollback_num,
  output logic             id_stall,
  output logic [CNT_W-1:0] fl_free_cnt,
  output logic             fl_busy,
  output logic             fl_err
);

  localparam logic [8:0] CntMax = 9'(FREE_INIT);

  fl_state_e        fsm_q, fsm_d;
  logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             err_q, err_d;

  logic [1:0] req, ret, grant, rb;
  // Wide intermediates so saturation and the invariant check see true sums.
  logic [8:0] free_sum, remain_sum;

  assign req   = min2(id_req_num);
  assign ret   = min2(rob_retire_num);
  assign grant = (free_cnt_q < CNT_W'(req)) ? free_cnt_q[1:0] : req;
  assign rb    = (remain_q >= CNT_W'(2)) ? 2'd2 : remain_q[1:0];

  // Grant/rollback decode and next-state computation.
  always_comb begin
    fl_dispatch_num = 2'd0;
    fl_rollback_num = 2'd0;
    id_stall        = 1'b1;
    fl_busy         = 1'b0;
    fsm_d           = fsm_q;
    free_sum        = 9'(free_cnt_q);
    remain_sum      = 9'(remain_q);

    unique case (fsm_q)
      StNormal: begin
        if (rob_squash) begin
          // Squash wins over dispatch; retired tags still return this cycle.
          id_stall   = (req != 2'd0);
          free_sum   = 9'(free_cnt_q) + 9'(ret);
          remain_sum = 9'(rob_squash_cnt);
          fsm_d      = (rob_squash_cnt != '0) ? StRecover : StNormal;
        end else begin
          // Retired tags are not bypassed into this cycle's grant.
          fl_dispatch_num = grant;
          id_stall        = (req > grant);
          free_sum        = 9'(free_cnt_q) - 9'(grant) + 9'(ret);
          remain_sum      = 9'(remain_q);
        end
      end
      StRecover: begin
        fl_rollback_num = rb;
        fl_busy         = 1'b1;
        free_sum        = 9'(free_cnt_q) + 9'(rb) + 9'(ret);
        remain_sum      = 9'(remain_q) - 9'(rb) + (rob_squash ? 9'(rob_squash_cnt) : 9'd0);
        fsm_d           = (rob_squash || (remain_sum != 9'd0)) ? StRecover : StNormal;
      end
      default: fsm_d = StNormal;
    endcase

    free_cnt_d = (free_sum > CntMax) ? CNT_W'(FREE_INIT) : free_sum[CNT_W-1:0];
    remain_d   = (remain_sum > CntMax) ? CNT_W'(FREE_INIT) : remain_sum[CNT_W-1:0];
    err_d      = err_q | ((free_sum + remain_sum) > CntMax);

    // Hold the free list quiet and dispatch stalled while in reset.
    if (reset) begin
      fl_dispatch_num = 2'd0;
      fl_rollback_num = 2'd0;
      id_stall        = 1'b1;
      fl_busy         = 1'b0;
    end
  end

  // State register with synchronous reset to the fully-mapped free pool.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q      <= StNormal;
      free_cnt_q <= CNT_W'(FREE_INIT);
      remain_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      free_cnt_q <= free_cnt_d;
      remain_q   <= remain_d;
      err_q      <= err_d;
    end
  end

  assign fl_free_cnt = free_cnt_q;
  assign fl_err      = err_q;

endmodule

// File: tb/tb_fl_alloc_ctrl.sv
// Self-checking bench for fl_alloc_ctrl: expectations queued at drive time,
// popped and compared at the following negedge.
module tb_fl_alloc_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] id_req_num = 2'd0;
  logic [1:0] rob_retire_num = 2'd0;
  logic       rob_squash = 1'b0;
  logic [6:0] rob_squash_cnt = 7'd0;
  logic [1:0] fl_dispatch_num, fl_rollback_num;
  logic       id_stall, fl_busy, fl_err;
  logic [6:0] fl_free_cnt;

  typedef struct packed {
    logic [1:0] disp;
    logic [1:0] rb;
    logic       stall;
    logic       busy;
    logic [6:0] free;
    logic       err;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fl_alloc_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .id_req_num     (id_req_num),
    .rob_retire_num (rob_retire_num),
    .rob_squash     (rob_squash),
    .rob_squash_cnt (rob_squash_cnt),
    .fl_dispatch_num(fl_dispatch_num),
    .fl_rollback_num(fl_rollback_num),
    .id_stall       (id_stall),
    .fl_free_cnt    (fl_free_cnt),
    .fl_busy        (fl_busy),
    .fl_err         (fl_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic [1:0] d, input logic [1:0] r, input logic s,
                              input logic b, input logic [6:0] f, input logic e);
    obs_t o;
    o.disp = d; o.rb = r; o.stall = s; o.busy = b; o.free = f; o.err = e;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(fl_dispatch_num, fl_rollback_num, id_stall, fl_busy, fl_free_cnt, fl_err);
  endfunction

  // Drive one cycle of stimulus and queue its expected outputs.
  task automatic drive(input logic [1:0] req, input logic [1:0] ret, input logic sq,
                       input logic [6:0] cnt, input obs_t e);
    id_req_num     = req;
    rob_retire_num = ret;
    rob_squash     = sq;
    rob_squash_cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Unchecked setup cycle.
  task automatic setup_cycle(input logic rst, input logic [1:0] req);
    reset = rst; id_req_num = req; rob_retire_num = 2'd0; rob_squash = 1'b0;
    rob_squash_cnt = 7'd0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    obs_t got, want;
    reset = 1'b1;
    @(posedge clock); #1;
    drive(2'd2, 2'd1, 1'b1, 7'd9, mk(2'd0, 2'd0, 1'b1, 1'b0, 7'd64, 1'b0));
    @(negedge clock);
    got = sample(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset: got %p required %p", got, want);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_drain();
    obs_t got, want;
    for (int i = 0; i < 33; i++) begin
      if (i < 32) drive(2'd2, 2'd0, 1'b0, 7'd0, mk(2'd2, 2'd0, 1'b0, 1'b0, 7'(64 - 2 * i), 1'b0));
      else        drive(2'd2, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd0, 1'b1, 1'b0, 7'd0, 1'b0));
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL drain cyc %0d: got %p required %p", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_partial_grant();
    obs_t got, want;
    drive(2'd0, 2'd1, 1'b0, 7'd0, mk(2'd0, 2'd0, 1'b0, 1'b0, 7'd0, 1'b0));
    drive(2'd3, 2'd2, 1'b0, 7'd0, mk(2'd1, 2'd0, 1'b1, 1'b0, 7'd1, 1'b0));
    drive(2'd0, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd0, 1'b0, 1'b0, 7'd2, 1'b0));
    for (int i = 0; i < 3; i++) begin
      // Reapply the i-th stimulus; queue order matches.
      case (i)
        0: begin id_req_num = 2'd0; rob_retire_num = 2'd1; end
        1: begin id_req_num = 2'd3; rob_retire_num = 2'd2; end
        default: begin id_req_num = 2'd0; rob_retire_num = 2'd0; end
      endcase
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL partial_grant cyc %0d: got %p required %p", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_squash();
    obs_t got, want;
    setup_cycle(1'b1, 2'd0);
    for (int i = 0; i < 12; i++) setup_cycle(1'b0, 2'd2);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(2'd2, 2'd0, 1'b1, 7'd5, mk(2'd0, 2'd0, 1'b1, 1'b0, 7'd40, 1'b0));
        1: drive(2'd2, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd2, 1'b1, 1'b1, 7'd40, 1'b0));
        2: drive(2'd2, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd2, 1'b1, 1'b1, 7'd42, 1'b0));
        3: drive(2'd2, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd1, 1'b1, 1'b1, 7'd44, 1'b0));
        4: drive(2'd2, 2'd0, 1'b0, 7'd0, mk(2'd2, 2'd0, 1'b0, 1'b0, 7'd45, 1'b0));
        default: drive(2'd0, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd0, 1'b0, 1'b0, 7'd43, 1'b0));
      endcase
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL squash cyc %0d: got %p required %p", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back_squash();
    obs_t got, want;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drive(2'd0, 2'd0, 1'b1, 7'd4, mk(2'd0, 2'd0, 1'b0, 1'b0, 7'd43, 1'b0));
        1: drive(2'd1, 2'd0, 1'b1, 7'd3, mk(2'd0, 2'd2, 1'b1, 1'b1, 7'd43, 1'b0));
        2: drive(2'd1, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd2, 1'b1, 1'b1, 7'd45, 1'b0));
        3: drive(2'd1, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd2, 1'b1, 1'b1, 7'd47, 1'b0));
        4: drive(2'd1, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd1, 1'b1, 1'b1, 7'd49, 1'b0));
        default: drive(2'd0, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd0, 1'b0, 1'b0, 7'd50, 1'b0));
      endcase
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL b2b_squash cyc %0d: got %p required %p", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_saturate();
    obs_t got, want;
    setup_cycle(1'b1, 2'd0);
    setup_cycle(1'b0, 2'd1);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(2'd0, 2'd2, 1'b0, 7'd0, mk(2'd0, 2'd0, 1'b0, 1'b0, 7'd63, 1'b0));
        1: drive(2'd0, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd0, 1'b0, 1'b0, 7'd64, 1'b1));
        2: drive(2'd2, 2'd0, 1'b0, 7'd0, mk(2'd2, 2'd0, 1'b0, 1'b0, 7'd64, 1'b1));
        3: drive(2'd2, 2'd2, 1'b0, 7'd0, mk(2'd2, 2'd0, 1'b0, 1'b0, 7'd62, 1'b1));
        default: drive(2'd0, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd0, 1'b0, 1'b0, 7'd62, 1'b1));
      endcase
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL saturate cyc %0d: got %p required %p", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  // Continues from free=62, err=1; reset mid-recovery must clear everything.
  task automatic test_reset_mid_recover();
    obs_t got, want;
    for (int i = 0; i < 6; i++) setup_cycle(1'b0, 2'd2);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(2'd0, 2'd0, 1'b1, 7'd10, mk(2'd0, 2'd0, 1'b0, 1'b0, 7'd50, 1'b1));
        1: drive(2'd0, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd2, 1'b1, 1'b1, 7'd50, 1'b1));
        2: begin
          reset = 1'b1;
          drive(2'd2, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd0, 1'b1, 1'b0, 7'd52, 1'b1));
        end
        3: begin
          reset = 1'b0;
          drive(2'd0, 2'd0, 1'b0, 7'd0, mk(2'd0, 2'd0, 1'b0, 1'b0, 7'd64, 1'b0));
        end
        default: drive(2'd2, 2'd0, 1'b0, 7'd0, mk(2'd2, 2'd0, 1'b0, 1'b0, 7'd64, 1'b0));
      endcase
      @(negedge clock);
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid_recover cyc %0d: got %p required %p", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_partial_grant();
    test_squash();
    test_back_to_back_squash();
    test_saturate();
    test_reset_mid_recover();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
